// File: rtl/seq_divider.sv
// Signed restoring divider, one quotient bit per cycle, MIPS div semantics.
// Latency: WIDTH+1 edges from accepted start to done; divide-by-zero reports in 1 edge.
// Backpressure: none; start is sampled only in IDLE and ignored while busy.
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   start, a, b       request plus dividend/divisor (two's complement)
//   quotient          signed quotient, held until the next successful completion
//   remainder         signed remainder (sign of dividend), held likewise
//   done              one-cycle completion pulse
//   div_by_zero       valid with done, held until the next accepted start
//   busy              high in RUN and FIX
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             done,
    output logic             div_by_zero,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] rem_q;      // partial remainder
    logic [WIDTH-1:0] dq_q;       // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0] dvs_q;      // divisor magnitude
    logic [CW-1:0]    cnt_q;
    logic             sign_q_q;   // quotient negative
    logic             sign_r_q;   // remainder negative (sign of dividend)

    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH:0]   trial_sub;
    logic [WIDTH-1:0] rem_d;
    logic [WIDTH-1:0] dq_d;

    // Magnitudes stay WIDTH bits: the most negative value negates to itself,
    // which read as unsigned is exactly its magnitude.
    always_comb begin
        abs_a = a[WIDTH-1] ? -a : a;
        abs_b = b[WIDTH-1] ? -b : b;
    end

    // One restoring step. The shifted remainder needs WIDTH+1 bits because the
    // divisor magnitude may be as large as 2^(WIDTH-1); the borrow bit of the
    // trial subtraction decides keep vs restore.
    always_comb begin
        trial_sub = {rem_q, dq_q[WIDTH-1]} - {1'b0, dvs_q};
        if (!trial_sub[WIDTH]) begin
            rem_d = trial_sub[WIDTH-1:0];
            dq_d  = {dq_q[WIDTH-2:0], 1'b1};
        end else begin
            rem_d = {rem_q[WIDTH-2:0], dq_q[WIDTH-1]};
            dq_d  = {dq_q[WIDTH-2:0], 1'b0};
        end
    end

    assign busy = (state_q != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            dq_q        <= '0;
            dvs_q       <= '0;
            cnt_q       <= '0;
            sign_q_q    <= 1'b0;
            sign_r_q    <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (b == '0) begin
                            // Report immediately; previous results stay visible.
                            done        <= 1'b1;
                            div_by_zero <= 1'b1;
                        end else begin
                            sign_q_q    <= a[WIDTH-1] ^ b[WIDTH-1];
                            sign_r_q    <= a[WIDTH-1];
                            dq_q        <= abs_a;
                            dvs_q       <= abs_b;
                            rem_q       <= '0;
                            cnt_q       <= '0;
                            div_by_zero <= 1'b0;
                            state_q     <= RUN;
                        end
                    end
                end
                RUN: begin
                    rem_q <= rem_d;
                    dq_q  <= dq_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST_ITER) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    // -2^(W-1) / -1 yields magnitude 2^(W-1) with a positive
                    // sign, which wraps to 0x80..0 as MIPS expects.
                    quotient  <= sign_q_q ? -dq_q : dq_q;
                    remainder <= sign_r_q ? -rem_q : rem_q;
                    done      <= 1'b1;
                    state_q   <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         done;
    logic         div_by_zero;
    logic         busy;

    int n_chk  = 0;
    int n_fail = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .a           (a),
        .b           (b),
        .quotient    (quotient),
        .remainder   (remainder),
        .done        (done),
        .div_by_zero (div_by_zero),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic: C-style truncating division on 64-bit signed values.
    function automatic void ref_div(input logic [W-1:0] x, input logic [W-1:0] y,
                                    output logic [W-1:0] q, output logic [W-1:0] r);
        longint sx;
        longint sy;
        longint lq;
        longint lr;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        lq = sx / sy;
        lr = sx % sy;
        q  = lq[W-1:0];
        r  = lr[W-1:0];
    endfunction

    // Timeline model: an accepted op finishes WIDTH+1 edges after acceptance.
    int           m_left = 0;
    logic [W-1:0] m_q = '0, m_r = '0, p_q = '0, p_r = '0;
    logic         m_done = 1'b0, m_dz = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_left = 0;
            m_q    = '0;
            m_r    = '0;
            m_done = 1'b0;
            m_dz   = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_left == 0) begin
                if (start) begin
                    if (b == '0) begin
                        m_done = 1'b1;
                        m_dz   = 1'b1;
                    end else begin
                        m_dz   = 1'b0;
                        ref_div(a, b, p_q, p_r);
                        m_left = W + 1;
                    end
                end
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_q    = p_q;
                    m_r    = p_r;
                    m_done = 1'b1;
                end
            end
        end
    end

    logic cmp_en = 1'b0;

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc_done", {31'd0, done}, {31'd0, m_done});
            chk("cyc_busy", {31'd0, busy}, {31'd0, m_left != 0});
            chk("cyc_dz", {31'd0, div_by_zero}, {31'd0, m_dz});
            chk("cyc_quot", quotient, m_q);
            chk("cyc_rem", remainder, m_r);
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_quot"}, quotient, '0);
        chk({tag, "_rem"}, remainder, '0);
        chk({tag, "_done"}, {31'd0, done}, '0);
        chk({tag, "_dz"}, {31'd0, div_by_zero}, '0);
        chk({tag, "_busy"}, {31'd0, busy}, '0);
    endtask

    // Issue one op and wait for done; checks literal results, the done edge
    // index relative to the accepting edge, and the number of busy cycles.
    task automatic do_op(input logic [W-1:0] xa, input logic [W-1:0] xb,
                         input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz);
        int c;
        int nbusy;
        start = 1'b1;
        a     = xa;
        b     = xb;
        step();
        start = 1'b0;
        c     = 1;
        nbusy = 0;
        while (!done && c < 60) begin
            if (busy) nbusy++;
            step();
            c++;
        end
        if (!done) begin
            n_chk++;
            n_fail++;
            $display("FAIL op_timeout: no done for %h/%h after %0d cycles", xa, xb, c);
        end else begin
            chk("op_quot", quotient, eq);
            chk("op_rem", remainder, er);
            chk("op_dz", {31'd0, div_by_zero}, {31'd0, edz});
            chk("op_done_edge", c - 1, edz ? 0 : W + 1);
            chk("op_busy_cycles", nbusy, edz ? 0 : W + 1);
        end
    endtask

    function automatic logic [W-1:0] pick();
        logic [W-1:0] v;
        case ($urandom_range(0, 7))
            0: v = '0;
            1: v = 32'hFFFF_FFFF;
            2: v = 32'h8000_0000;
            3: v = 32'h7FFF_FFFF;
            4: begin
                v = 32'($urandom_range(1, 20));
                if ($urandom_range(0, 1) == 1) v = -v;
            end
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        logic [W-1:0] tq, tr;

        // Pin the reference arithmetic with hand-computed values.
        ref_div(32'd100, 32'd7, tq, tr);
        chk("ref_100_7_q", tq, 32'd14);
        chk("ref_100_7_r", tr, 32'd2);
        ref_div(32'hFFFF_FFF9, 32'd2, tq, tr);
        chk("ref_m7_2_q", tq, 32'hFFFF_FFFD);
        chk("ref_m7_2_r", tr, 32'hFFFF_FFFF);
        ref_div(32'd7, 32'hFFFF_FFFE, tq, tr);
        chk("ref_7_m2_q", tq, 32'hFFFF_FFFD);
        chk("ref_7_m2_r", tr, 32'd1);
        ref_div(32'h8000_0000, 32'hFFFF_FFFF, tq, tr);
        chk("ref_ovf_q", tq, 32'h8000_0000);
        chk("ref_ovf_r", tr, 32'd0);

        reset = 1'b1;
        repeat (3) step();
        chk_zero_outputs("reset");
        cmp_en = 1'b1;
        reset  = 1'b0;

        do_op(32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
        do_op(32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        do_op(32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0);
        do_op(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
        do_op(32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
        do_op(32'd5, 32'd0, 32'd14, 32'd2, 1'b1);
        do_op(32'd9, 32'd9, 32'd1, 32'd0, 1'b0);

        // Abort mid-operation; a start pulse while busy must be ignored.
        start = 1'b1;
        a     = 32'd1000;
        b     = 32'd3;
        for (int i = 1; i <= 10; i++) begin
            step();
            start = (i == 5);
            a     = (i == 5) ? 32'd9 : 32'd1000;
            b     = (i == 5) ? 32'd9 : 32'd3;
            if (i == 10) reset = 1'b1;
        end
        step();
        chk_zero_outputs("abort");
        reset = 1'b0;
        do_op(32'd9, 32'd9, 32'd1, 32'd0, 1'b0);

        // Back-to-back: second start lands on the done cycle.
        do_op(32'd50, 32'd5, 32'd10, 32'd0, 1'b0);
        do_op(32'd51, 32'd5, 32'd10, 32'd1, 1'b0);

        // Random traffic with stray starts and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            step();
            reset = ($urandom_range(0, 499) == 0);
            start = ($urandom_range(0, 3) == 0);
            a     = pick();
            b     = pick();
        end
        step();
        reset = 1'b0;
        start = 1'b0;
        repeat (40) step();

        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/seq_divider.md
# seq_divider

Iterative signed restoring divider: the responder side of the datapath's `DivStart` / `done` handshake. The control FSM pulses `start` with operands taken from the A/B intermediate registers. The unit computes one quotient bit per cycle and returns quotient (for LO), remainder (for HI) and a divide-by-zero flag (for the exception unit). Semantics follow MIPS `div`: truncation toward zero, remainder takes the sign of the dividend.

## Interface

- `WIDTH`, 32, operand/result width in bits

- `clk`  in  1  system clock, rising-edge active
- `reset`  in  1  asynchronous, active-high reset
- `start`  in  1  request; sampled only in IDLE
- `a`  in  WIDTH  dividend, two's complement; sampled with `start`
- `b`  in  WIDTH  divisor, two's complement; sampled with `start`
- `quotient`  out  WIDTH  signed quotient; held until next successful completion
- `remainder`  out  WIDTH  signed remainder; held likewise
- `done`  out  1  one-cycle completion pulse
- `div_by_zero`  out  1  valid with `done`; held until next accepted `start`
- `busy`  out  1  high while an operation is in progress

## Operation

- Reset: state IDLE; `quotient`, `remainder`, `done`, `div_by_zero`, `busy` all 0; internal iteration registers cleared.
- States: IDLE, RUN, FIX.
- IDLE, `start`=1, `b`=0:
  - `done` <= 1 and `div_by_zero` <= 1.
  - `quotient`/`remainder` unchanged.
  - Stay in IDLE.
- IDLE, `start`=1, `b`≠0:
  - Latch `sign_q` = a[MSB]^b[MSB] and `sign_r` = a[MSB].
  - Load |a| into the dividend/quotient shift register and |b| into the divisor register.
  - Partial remainder <= 0, counter <= 0, `div_by_zero` <= 0, go to RUN.
- Magnitude rule: |x| is computed in WIDTH bits. |−2^(WIDTH−1)| = 2^(WIDTH−1) is treated as unsigned, so no extra bit is needed.
- RUN, one iteration per cycle:
  - Shift {partial remainder, dividend} left by 1.
  - Trial-subtract the divisor, using a WIDTH+1-bit subtraction.
  - If the result is non-negative, keep it and set the new LSB of the quotient to 1; else restore and set LSB to 0.
  - Counter increments. After iteration WIDTH (counter = WIDTH−1 at the edge), go to FIX.
- FIX:
  - `quotient` <= `sign_q` ? −q : q.
  - `remainder` <= `sign_r` ? −r : r.
  - `done` <= 1, go to IDLE.
- `done` is cleared on every edge where it is not being set; it is never high for two consecutive cycles.
- `busy` = 1 in RUN and FIX, 0 in IDLE (combinational from state).
- `start` in RUN/FIX is ignored: no restart, operands not resampled.
- Overflow case −2^(WIDTH−1) / −1:
  - Result `quotient` = 0x80000000, `remainder` = 0.
  - No flag, no trap (matches MIPS).
- Remainder invariant: a = quotient*b + remainder, and |remainder| < |b|.

## Timing

- Let E0 be the edge that samples `start`=1 in IDLE.
- Normal op:
  - RUN occupies edges E1..E32 (WIDTH iterations).
  - FIX executes at E33; `quotient`, `remainder` and `done` update at E33.
  - `done` is high for the cycle E33→E34. Latency is WIDTH+1 edges.
- Divide-by-zero: `done` and `div_by_zero` update at E0 and `done` is high for E0→E1. Latency is 1 edge.
- Back-to-back: the unit is in IDLE during the `done` cycle, so `start` sampled at the very next edge (E34) is accepted.
- Reset mid-operation:
  - Immediate return to IDLE with all outputs 0, asynchronously.
  - No `done` for the aborted op.
  - First `start` after reset deassertion is accepted normally.
- `start` and `reset` together: reset wins.

## Test plan

- a=100, b=7 -> after 33 edges `done`=1 for one cycle, `quotient`=14, `remainder`=2, `div_by_zero`=0, `busy` high for 33 cycles.
- a=−7 (0xFFFFFFF9), b=2 -> `quotient`=0xFFFFFFFD (−3), `remainder`=0xFFFFFFFF (−1); repeat with a=7, b=−2 -> `quotient`=−3, `remainder`=1.
- a=0x80000000, b=0xFFFFFFFF -> `quotient`=0x80000000, `remainder`=0, `div_by_zero`=0.
- After a completed 100/7, issue a=5, b=0 -> `done` and `div_by_zero` high one edge later; `quotient`=14 and `remainder`=2 retained. The next valid `start` clears `div_by_zero`.
- Start 1000/3; pulse `start` with 9/9 at cycle 5 (ignored); assert `reset` at cycle 10 -> outputs 0, no `done`. Then run 9/9 -> `quotient`=1, `remainder`=0 after 33 edges.
- Two ops back-to-back, second `start` asserted the cycle `done` is high -> both complete, second `done` 33 edges after its `start`, results correct (e.g. 50/5 then 51/5 -> 10 r0, 10 r1).
